// File: rtl/fsm_moore_1101_if.sv
// Serial bit-stream link into the 1101 sequence detector.
// The source drives data_in and observes the Moore detect flag on out.
interface fsm_moore_1101_if;
  logic data_in;
  logic out;

  modport master (output data_in, input out);
  modport slave  (input data_in, output out);
endinterface

// File: rtl/fsm_moore_1101.sv
// Moore detector for the serial pattern 1-1-0-1, sync-word front end.
// The flag is a flop loaded from the next state, so it is glitch-free and coincident with S4.
module fsm_moore_1101 #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  fsm_moore_1101_if.slave    bus
);

  // state | meaning
  // S0    | idle, no prefix seen
  // S1    | "1"
  // S2    | "11" (a run of ones stays here)
  // S3    | "110"
  // S4    | "1101" detect, out high
  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       out_q;

  always_comb begin
    state_d = S0;
    case (state_q)
      S0: state_d = bus.data_in ? S1 : S0;
      S1: state_d = bus.data_in ? S2 : S0;
      S2: state_d = bus.data_in ? S2 : S3;
      S3: state_d = bus.data_in ? S4 : S0;
      // The trailing '1' either seeds a new "11" prefix or counts only as a lone "1".
      S4: state_d = bus.data_in ? (OVERLAP ? S2 : S1) : S0;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= (state_d == S4);
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_fsm_moore_1101.sv
// Directed bench for fsm_moore_1101: overlapping and non-overlapping instances share one stimulus stream.
module tb_fsm_moore_1101;

  logic clk;
  logic rst_n;

  fsm_moore_1101_if bus_ov ();
  fsm_moore_1101_if bus_nov ();

  fsm_moore_1101 #(.OVERLAP(1'b1)) dut_ov  (.clk(clk), .rst_n(rst_n), .bus(bus_ov.slave));
  fsm_moore_1101 #(.OVERLAP(1'b0)) dut_nov (.clk(clk), .rst_n(rst_n), .bus(bus_nov.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic din;
    logic exp_ov;
    logic exp_nov;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic d, input logic o, input logic n);
    vec_t v;
    v.din = d; v.exp_ov = o; v.exp_nov = n;
    vecs.push_back(v);
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    bus_ov.data_in  = b;
    bus_nov.data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_async_ov", bus_ov.out, 1'b0);
    check("reset_async_nov", bus_nov.out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus_ov.data_in  = 1'b0;
    bus_nov.data_in = 1'b0;

    // idle after reset
    repeat (5) add(0, 0, 0);
    // basic match
    add(1, 0, 0); add(1, 0, 0); add(0, 0, 0); add(1, 1, 1);
    // overlap continuation 1,1,0,0,1,1,0,1,1
    add(1, 0, 0); add(1, 0, 0); add(0, 0, 0); add(0, 0, 0);
    add(1, 0, 0); add(1, 0, 0); add(0, 0, 0); add(1, 1, 1); add(1, 0, 0);
    add(0, 0, 0); add(0, 0, 0);
    // 1101101: two pulses with overlap, one without
    add(1, 0, 0); add(1, 0, 0); add(0, 0, 0); add(1, 1, 1);
    add(1, 0, 0); add(0, 0, 0); add(1, 1, 0);
    add(0, 0, 0);
    // 11011101: two pulses in both modes
    add(1, 0, 0); add(1, 0, 0); add(0, 0, 0); add(1, 1, 1);
    add(1, 0, 0); add(1, 0, 0); add(0, 0, 0); add(1, 1, 1);
    add(0, 0, 0);
    // near misses
    add(1, 0, 0); add(0, 0, 0); add(1, 0, 0); add(1, 0, 0); add(0, 0, 0);
    add(0, 0, 0); add(1, 0, 0); add(0, 0, 0); add(1, 0, 0);
    add(0, 0, 0);
    add(1, 0, 0); add(1, 0, 0); add(1, 0, 0); add(1, 0, 0); add(0, 0, 0); add(0, 0, 0);
    // run of ones then 01 still detects
    add(1, 0, 0); add(1, 0, 0); add(1, 0, 0); add(0, 0, 0); add(1, 1, 1);
    add(0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("in_reset_ov", bus_ov.out, 1'b0);
    check("in_reset_nov", bus_nov.out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_bit(vecs[i].din);
      check($sformatf("vec%0d_ov", i), bus_ov.out, vecs[i].exp_ov);
      check($sformatf("vec%0d_nov", i), bus_nov.out, vecs[i].exp_nov);
    end

    // asynchronous reset while out is high
    drive_bit(1); drive_bit(1); drive_bit(0); drive_bit(1);
    check("pre_async_ov", bus_ov.out, 1'b1);
    check("pre_async_nov", bus_nov.out, 1'b1);
    do_reset();
    check3("after_async_state", dut_ov.state_q, 3'd0);

    // reset mid-sequence discards the partial match
    drive_bit(1); drive_bit(1); drive_bit(0);
    check3("partial_state", dut_ov.state_q, 3'd3);
    do_reset();
    drive_bit(1);
    check("midseq_out_ov", bus_ov.out, 1'b0);
    check("midseq_out_nov", bus_nov.out, 1'b0);
    check3("midseq_state_ov", dut_ov.state_q, 3'd1);
    check3("midseq_state_nov", dut_nov.state_q, 3'd1);
    drive_bit(0);
    check("midseq_tail_ov", bus_ov.out, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
